dice_roll_engine: RTL and testbench

//  Sequential, unbiased dice-roll engine. Pulls random words from the RNG via a req/valid

---
 rtl/dice_roll_engine.sv | 198 +++++++++++++++++++
 tb/tb_dice_roll_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_engine.sv
// Dice-roll engine: pulls RNG words over a req/valid handshake, rejection-samples them to
// remove modulo bias, and sums 1..MAX_DICE dice of one type. Select 7 streams raw RNG words.
module dice_roll_engine #(
    parameter int unsigned RAND_W   = 8,
    parameter int unsigned MAX_DICE = 4,
    parameter int unsigned SUM_W    = 9,
    parameter int unsigned REJ_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [2:0]        i_dice_sel,
    input  logic [2:0]        i_dice_count,
    input  logic              i_abort,
    output logic              o_rand_req,
    input  logic              i_rand_valid,
    input  logic [RAND_W-1:0] i_rand_data,
    output logic              o_busy,
    output logic              o_roll_valid,
    output logic [SUM_W-1:0]  o_roll_sum,
    output logic [REJ_W-1:0]  o_reject_cnt,
    output logic              o_test_valid,
    output logic [RAND_W-1:0] o_test_data
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_EVAL = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_TEST = 3'd4;

    localparam int unsigned RANGE = 1 << RAND_W;

    // Largest multiple of SIDES that fits in the RNG range; samples at or above it are rejected.
    localparam logic [RAND_W:0] LIM_D4   = (RAND_W+1)'((RANGE / 4) * 4);
    localparam logic [RAND_W:0] LIM_D6   = (RAND_W+1)'((RANGE / 6) * 6);
    localparam logic [RAND_W:0] LIM_D8   = (RAND_W+1)'((RANGE / 8) * 8);
    localparam logic [RAND_W:0] LIM_D10  = (RAND_W+1)'((RANGE / 10) * 10);
    localparam logic [RAND_W:0] LIM_D12  = (RAND_W+1)'((RANGE / 12) * 12);
    localparam logic [RAND_W:0] LIM_D20  = (RAND_W+1)'((RANGE / 20) * 20);
    localparam logic [RAND_W:0] LIM_D100 = (RAND_W+1)'((RANGE / 100) * 100);

    localparam logic [RAND_W-1:0] SD4   = RAND_W'(4);
    localparam logic [RAND_W-1:0] SD6   = RAND_W'(6);
    localparam logic [RAND_W-1:0] SD8   = RAND_W'(8);
    localparam logic [RAND_W-1:0] SD10  = RAND_W'(10);
    localparam logic [RAND_W-1:0] SD12  = RAND_W'(12);
    localparam logic [RAND_W-1:0] SD20  = RAND_W'(20);
    localparam logic [RAND_W-1:0] SD100 = RAND_W'(100);

    logic [2:0]        state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        remaining_q, remaining_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [SUM_W-1:0]  roll_sum_q, roll_sum_d;
    logic [RAND_W-1:0] sample_q, sample_d;
    logic [REJ_W-1:0]  reject_q, reject_d;
    logic              test_valid_q, test_valid_d;
    logic [RAND_W-1:0] test_data_q, test_data_d;

    logic [RAND_W:0]   limit;
    logic [RAND_W-1:0] die;
    logic              accept;
    logic [SUM_W-1:0]  die_sum;
    logic [2:0]        count_clamped;
    logic              beat;

    assign o_rand_req   = (state_q == ST_REQ) || (state_q == ST_TEST);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_roll_valid = (state_q == ST_DONE);
    assign o_roll_sum   = roll_sum_q;
    assign o_reject_cnt = reject_q;
    assign o_test_valid = test_valid_q;
    assign o_test_data  = test_data_q;

    assign beat = o_rand_req && i_rand_valid;

    // Per-die limit and face value; each modulo is by a constant, so no divider is built.
    always_comb begin
        limit = LIM_D4;
        die   = sample_q % SD4;
        case (sel_q)
            3'd1: begin limit = LIM_D6;   die = sample_q % SD6;   end
            3'd2: begin limit = LIM_D8;   die = sample_q % SD8;   end
            3'd3: begin limit = LIM_D10;  die = sample_q % SD10;  end
            3'd4: begin limit = LIM_D12;  die = sample_q % SD12;  end
            3'd5: begin limit = LIM_D20;  die = sample_q % SD20;  end
            3'd6: begin limit = LIM_D100; die = sample_q % SD100; end
            default: begin limit = LIM_D4; die = sample_q % SD4;  end
        endcase
    end

    assign accept  = ({1'b0, sample_q} < limit);
    assign die_sum = sum_q + SUM_W'(die) + SUM_W'(1);

    // Requested dice count: 0 means one die, anything above MAX_DICE is clamped.
    always_comb begin
        count_clamped = i_dice_count;
        if (i_dice_count == 3'd0) begin
            count_clamped = 3'd1;
        end else if (32'(i_dice_count) > MAX_DICE) begin
            count_clamped = 3'(MAX_DICE);
        end
    end

    // Next-state logic; abort wins over every other event, including a same-cycle beat.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        remaining_d  = remaining_q;
        sum_d        = sum_q;
        roll_sum_d   = roll_sum_q;
        sample_d     = sample_q;
        reject_d     = reject_q;
        test_valid_d = 1'b0;
        test_data_d  = test_data_q;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_dice_sel == 3'd7) begin
                            state_d = ST_TEST;
                        end else begin
                            sel_d       = i_dice_sel;
                            remaining_d = count_clamped;
                            sum_d       = '0;
                            reject_d    = '0;
                            state_d     = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (beat) begin
                        sample_d = i_rand_data;
                        state_d  = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (!accept) begin
                        if (reject_q != '1) begin
                            reject_d = reject_q + REJ_W'(1);
                        end
                        state_d = ST_REQ;
                    end else begin
                        sum_d       = die_sum;
                        remaining_d = remaining_q - 3'd1;
                        if (remaining_q == 3'd1) begin
                            roll_sum_d = die_sum;
                            state_d    = ST_DONE;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                ST_TEST: begin
                    if (beat) begin
                        test_data_d  = i_rand_data;
                        test_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            remaining_q  <= '0;
            sum_q        <= '0;
            roll_sum_q   <= '0;
            sample_q     <= '0;
            reject_q     <= '0;
            test_valid_q <= 1'b0;
            test_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            remaining_q  <= remaining_d;
            sum_q        <= sum_d;
            roll_sum_q   <= roll_sum_d;
            sample_q     <= sample_d;
            reject_q     <= reject_d;
            test_valid_q <= test_valid_d;
            test_data_q  <= test_data_d;
        end
    end

endmodule

// File: tb/tb_dice_roll_engine.sv
// Self-checking bench for dice_roll_engine: directed cases plus randomized rolls, test-stream,
// abort and mid-roll reset, all checked against a word-list reference model.
module tb_dice_roll_engine;

    localparam int RAND_W   = 8;
    localparam int MAX_DICE = 4;
    localparam int SUM_W    = 9;
    localparam int REJ_W    = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [2:0]        sel;
    logic [2:0]        cnt;
    logic              abort;
    logic              rand_req;
    logic              rand_valid;
    logic [RAND_W-1:0] rand_data;
    logic              busy;
    logic              roll_valid;
    logic [SUM_W-1:0]  roll_sum;
    logic [REJ_W-1:0]  reject_cnt;
    logic              test_valid;
    logic [RAND_W-1:0] test_data;

    int n_vec = 0;
    int n_err = 0;
    int words[$];
    int last_sum = 0;

    dice_roll_engine #(
        .RAND_W   (RAND_W),
        .MAX_DICE (MAX_DICE),
        .SUM_W    (SUM_W),
        .REJ_W    (REJ_W)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_start      (start),
        .i_dice_sel   (sel),
        .i_dice_count (cnt),
        .i_abort      (abort),
        .o_rand_req   (rand_req),
        .i_rand_valid (rand_valid),
        .i_rand_data  (rand_data),
        .o_busy       (busy),
        .o_roll_valid (roll_valid),
        .o_roll_sum   (roll_sum),
        .o_reject_cnt (reject_cnt),
        .o_test_valid (test_valid),
        .o_test_data  (test_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sides_of(input int s);
        case (s)
            0: return 4;
            1: return 6;
            2: return 8;
            3: return 10;
            4: return 12;
            5: return 20;
            default: return 100;
        endcase
    endfunction

    // Reference: walk the word list with the rejection-sampling rule until all dice are rolled.
    task automatic model(input int s, input int c, output int e_sum, output int e_rej,
                         output int e_beats, output int left);
        int sides;
        int limit;
        sides   = sides_of(s);
        limit   = ((1 << RAND_W) / sides) * sides;
        left    = (c == 0) ? 1 : ((c > MAX_DICE) ? MAX_DICE : c);
        e_sum   = 0;
        e_rej   = 0;
        e_beats = 0;
        foreach (words[i]) begin
            if (left == 0) break;
            e_beats++;
            if (words[i] >= limit) begin
                if (e_rej < (1 << REJ_W) - 1) e_rej++;
            end else begin
                e_sum += words[i] % sides + 1;
                left--;
            end
        end
    endtask

    task automatic fill_random(input int s, input int c);
        int es, er, eb, left;
        words.delete();
        left = 1;
        while (left > 0 && words.size() < 200) begin
            words.push_back(int'($urandom_range(0, (1 << RAND_W) - 1)));
            model(s, c, es, er, eb, left);
        end
    endtask

    // Run one roll from IDLE; words[] must already hold the RNG words to serve.
    task automatic do_roll(input int s, input int c, input int vpct, input string tag);
        int es, er, eb, left, idx, cyc;
        bit got, beat;
        model(s, c, es, er, eb, left);
        start = 1'b1;
        sel   = 3'(s);
        cnt   = 3'(c);
        @(posedge clk); #1;
        start = 1'b0;
        sel   = 3'($urandom);
        cnt   = 3'($urandom);
        idx = 0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 400) begin
            rand_valid = (int'($urandom_range(0, 99)) < vpct);
            rand_data  = (rand_valid && idx < words.size()) ? RAND_W'(words[idx])
                                                            : RAND_W'($urandom);
            @(negedge clk);
            if (roll_valid) begin
                got = 1'b1;
                check({tag, " sum"}, int'(roll_sum), es);
                check({tag, " rejects"}, int'(reject_cnt), er);
                check({tag, " beats"}, idx, eb);
                check({tag, " test_valid"}, int'(test_valid), 0);
                if (vpct == 100) check({tag, " latency"}, cyc, 2 * eb + 1);
            end
            beat = rand_req && rand_valid;
            @(posedge clk); #1;
            if (beat) idx++;
            cyc++;
        end
        if (!got) check({tag, " timeout"}, 0, 1);
        rand_valid = 1'b0;
        @(negedge clk);
        check({tag, " pulse width"}, int'(roll_valid), 0);
        check({tag, " idle"}, int'(busy), 0);
        check({tag, " sum hold"}, int'(roll_sum), es);
        last_sum = es;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, " no roll_valid"}, int'(roll_valid), 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stream();
        int q[$];
        start = 1'b1;
        sel   = 3'd7;
        cnt   = 3'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c < 4) begin
                rand_valid = (c == 0 || c == 2);
                rand_data  = (c == 0) ? 8'hA5 : ((c == 2) ? 8'h3C : RAND_W'($urandom));
            end else if (c < 26) begin
                rand_valid = ($urandom_range(0, 1) == 1);
                rand_data  = RAND_W'($urandom);
            end else begin
                rand_valid = 1'b0;
            end
            @(negedge clk);
            check("test req", int'(rand_req), 1);
            if (test_valid) begin
                if (q.size() == 0) check("test extra pulse", 1, 0);
                else check("test data", int'(test_data), q.pop_front());
            end
            if (rand_req && rand_valid) q.push_back(int'(rand_data));
            @(posedge clk); #1;
        end
        check("test leftover", q.size(), 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("test abort busy", int'(busy), 0);
        check("test abort req", int'(rand_req), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sel = '0; cnt = '0; abort = 1'b0;
        rand_valid = 1'b0; rand_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst req", int'(rand_req), 0);
        check("rst roll_valid", int'(roll_valid), 0);
        check("rst sum", int'(roll_sum), 0);
        check("rst rejects", int'(reject_cnt), 0);
        check("rst test_valid", int'(test_valid), 0);
        check("rst test_data", int'(test_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        words = '{11};            do_roll(1, 1, 100, "d6");
        words = '{240, 19};       do_roll(5, 1, 100, "d20 reject");
        words = '{0, 1, 2};       do_roll(0, 3, 100, "d4x3");
        words = '{0, 1, 2};       do_roll(0, 0, 100, "d4 count0");
        words = '{0, 1, 2, 3};    do_roll(0, 7, 100, "d4 count7");
        words = '{200, 199};      do_roll(6, 1, 100, "d100 reject");
        words = '{255};           do_roll(2, 1, 100, "d8 top");

        test_stream();

        // Abort in REQ with a beat in the same cycle; that beat must be dropped.
        fill_random(1, 4);
        start = 1'b1; sel = 3'd1; cnt = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            rand_valid = 1'b1;
            rand_data  = RAND_W'(words[0]);
            abort      = (c == 3);
            @(negedge clk);
            check("abort roll_valid", int'(roll_valid), 0);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        rand_valid = 1'b0;
        @(negedge clk);
        check("abort busy", int'(busy), 0);
        check("abort req", int'(rand_req), 0);
        check("abort sum kept", int'(roll_sum), last_sum);
        @(posedge clk); #1;
        idle_cycles(3, "after abort");
        fill_random(3, 2); do_roll(3, 2, 100, "post abort");

        // Asynchronous reset mid-roll.
        fill_random(4, 4);
        start = 1'b1; sel = 3'd4; cnt = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        rand_valid = 1'b1;
        rand_data  = RAND_W'(words[0]);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst req", int'(rand_req), 0);
        check("midrst sum", int'(roll_sum), 0);
        check("midrst rejects", int'(reject_cnt), 0);
        last_sum = 0;
        rand_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(3, "after reset");
        fill_random(0, 3); do_roll(0, 3, 100, "post reset");

        for (int i = 0; i < 40; i++) begin
            int s, c, vp;
            s  = int'($urandom_range(0, 6));
            c  = int'($urandom_range(0, 7));
            vp = ($urandom_range(0, 1) == 1) ? 100 : 60;
            fill_random(s, c);
            do_roll(s, c, vp, $sformatf("rand%0d sel%0d cnt%0d", i, s, c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
